// File: rtl/somador_sequencial_n.sv
// rtl/somador_sequencial_n.sv - multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock
//
// Purpose:
//    Adds or subtracts two WIDTH-bit operands one CHUNK-bit ripple slice per
//    clock, least-significant slice first. The result is held afterwards
//    together with the carry/overflow/zero flags. A start/busy/done handshake
//    connects it to the controlling FSM.
//
// Parameters:
//    WIDTH  operand/result width, >= 2, integer multiple of CHUNK
//    CHUNK  bits processed per clock, >= 1 (CHUNK == WIDTH -> single slice)
//
// Ports:
//    clk    in   clock, rising edge
//    rst    in   synchronous active-high reset
//    start  in   operation request, sampled only while idle
//    sub    in   0: A+B+Cin, 1: A-B (A + ~B + 1, Cin ignored)
//    A, B   in   operands, latched on the accepted start
//    Cin    in   carry-in for addition, latched on the accepted start
//    busy   out  high while slices are being processed
//    done   out  one-cycle pulse when S and flags become valid
//    S      out  result (partial while busy)
//    Cout   out  carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//    Cmsb   out  carry into bit WIDTH-1
//    Ovf    out  signed overflow, Cmsb ^ Cout
//    Zero   out  1 when S == 0

module somador_sequencial_n #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Cmsb,
   output logic             Ovf,
   output logic             Zero
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic             r_carry;
   logic [KW-1:0]    r_k;

   logic [CHUNK-1:0] w_slice_a;
   logic [CHUNK-1:0] w_slice_b;
   logic [CHUNK-1:0] w_slice_sum;
   logic             w_slice_cmsb;
   logic             w_slice_cout;
   logic [WIDTH-1:0] w_s_next;
   logic             w_last;

   // Operand slice selected by the slice counter.
   always_comb begin
      w_slice_a = '0;
      w_slice_b = '0;
      for (int j = 0; j < NSLICE; j++) begin
         if (r_k == KW'(j)) begin
            w_slice_a = r_op_a[j*CHUNK +: CHUNK];
            w_slice_b = r_op_b[j*CHUNK +: CHUNK];
         end
      end
   end

   // CHUNK-bit ripple adder. The carry entering the top bit of the slice is
   // kept as well: on the last slice it is the carry into bit WIDTH-1. With
   // CHUNK == 1 that is simply the incoming carry register.
   always_comb begin
      logic w_c;
      w_c          = r_carry;
      w_slice_sum  = '0;
      w_slice_cmsb = r_carry;
      for (int i = 0; i < CHUNK; i++) begin
         w_slice_sum[i] = w_slice_a[i] ^ w_slice_b[i] ^ w_c;
         if (i == CHUNK - 1) begin
            w_slice_cmsb = w_c;
         end
         w_c = (w_slice_a[i] & w_slice_b[i]) |
               (w_slice_a[i] & w_c) |
               (w_slice_b[i] & w_c);
      end
      w_slice_cout = w_c;
   end

   // Result with the current slice merged in at position k.
   always_comb begin
      w_s_next = S;
      for (int j = 0; j < NSLICE; j++) begin
         if (r_k == KW'(j)) begin
            w_s_next[j*CHUNK +: CHUNK] = w_slice_sum;
         end
      end
   end

   assign w_last = (r_k == K_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_carry <= 1'b0;
         r_k     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         S       <= '0;
         Cout    <= 1'b0;
         Cmsb    <= 1'b0;
         Ovf     <= 1'b0;
         Zero    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtraction is folded into an add of ~B with carry-in 1.
                  r_op_a  <= A;
                  r_op_b  <= B ^ {WIDTH{sub}};
                  r_carry <= sub ? 1'b1 : Cin;
                  r_k     <= '0;
                  S       <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               S       <= w_s_next;
               r_carry <= w_slice_cout;
               if (w_last) begin
                  r_k     <= '0;
                  Cout    <= w_slice_cout;
                  Cmsb    <= w_slice_cmsb;
                  Ovf     <= w_slice_cmsb ^ w_slice_cout;
                  Zero    <= (w_s_next == '0);
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_somador_sequencial_n.sv
// tb/tb_somador_sequencial_n.sv - self-checking bench for somador_sequencial_n

module tb_somador_sequencial_n;

   logic        clk;
   logic        rst;
   logic        start4;
   logic        start16;
   logic        sub_i;
   logic [15:0] a_i;
   logic [15:0] b_i;
   logic        cin_i;

   logic        busy4, done4, cout4, cmsb4, ovf4, zero4;
   logic [15:0] s4;
   logic        busy16, done16, cout16, cmsb16, ovf16, zero16;
   logic [15:0] s16;

   int checks;
   int failures;

   somador_sequencial_n #(.WIDTH(16), .CHUNK(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub_i), .A(a_i), .B(b_i),
      .Cin(cin_i), .busy(busy4), .done(done4), .S(s4), .Cout(cout4),
      .Cmsb(cmsb4), .Ovf(ovf4), .Zero(zero4)
   );

   somador_sequencial_n #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub_i), .A(a_i), .B(b_i),
      .Cin(cin_i), .busy(busy16), .done(done16), .S(s16), .Cout(cout16),
      .Cmsb(cmsb16), .Ovf(ovf16), .Zero(zero16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        cin;
      logic [15:0] s;
      logic        cout;
      logic        cmsb;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vecs [6];

   // Reference: whole-word arithmetic; carry into the MSB comes from the
   // low WIDTH-1 bits added on their own.
   function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic s, input logic c);
      int unsigned bx, cin, full, low;
      logic cout, cmsb;
      bx   = s ? (32'hFFFF & ~{16'h0, b}) : {16'h0, b};
      cin  = s ? 1 : (c ? 1 : 0);
      full = {16'h0, a} + bx + cin;
      low  = ({16'h0, a} & 32'h7FFF) + (bx & 32'h7FFF) + cin;
      cout = (full >> 16) != 0;
      cmsb = (low >> 15) != 0;
      return {full[15:0], cout, cmsb, cout ^ cmsb, (full[15:0] == 16'h0)};
   endfunction

   function automatic logic [19:0] res_of(input int which);
      if (which == 0) return {s4, cout4, cmsb4, ovf4, zero4};
      return {s16, cout16, cmsb16, ovf16, zero16};
   endfunction

   function automatic logic done_of(input int which);
      return (which == 0) ? done4 : done16;
   endfunction

   function automatic logic busy_of(input int which);
      return (which == 0) ? busy4 : busy16;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive operands and a one-cycle start; returns 1 time unit after the accept edge.
   task automatic issue(input int which, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c);
      @(negedge clk);
      a_i = a; b_i = b; sub_i = s; cin_i = c;
      if (which == 0) start4 = 1'b1; else start16 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; start16 = 1'b0;
   endtask

   // Counts edges after the accept edge until done is seen; -1 if it never comes.
   task automatic wait_done(input int which, input int maxc, output int cyc);
      cyc = -1;
      for (int k = 1; k <= maxc; k++) begin
         @(posedge clk); #1;
         if (done_of(which)) begin
            cyc = k;
            break;
         end
      end
   endtask

   initial begin
      int cyc;
      int pulses;
      logic [19:0] exp;
      logic [15:0] ra, rb;
      logic rs, rc;

      checks = 0; failures = 0;
      rst = 1'b1; start4 = 1'b0; start16 = 1'b0;
      sub_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;

      vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2202, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset with random inputs and start asserted
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         a_i = 16'($urandom); b_i = 16'($urandom);
         sub_i = 1'($urandom); cin_i = 1'($urandom);
         start4 = 1'b1; start16 = 1'b1;
      end
      @(posedge clk); #1;
      chk("reset_out4", {11'h0, busy4, done4, res_of(0)}, 32'h0);
      chk("reset_out16", {11'h0, busy16, done16, res_of(1)}, 32'h0);
      @(negedge clk);
      rst = 1'b0; start4 = 1'b0; start16 = 1'b0;
      @(posedge clk); #1;
      chk("reset_start_not_accepted", {30'h0, busy4, busy16}, 32'h0);

      // Directed table on both slice configurations
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 6; i++) begin
            issue(w, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            chk($sformatf("busy_after_accept w%0d v%0d", w, i), {31'h0, busy_of(w)}, 32'h1);
            wait_done(w, 10, cyc);
            chk($sformatf("latency w%0d v%0d", w, i), cyc, (w == 0) ? 4 : 1);
            chk($sformatf("result w%0d v%0d", w, i), {12'h0, res_of(w)},
                {12'h0, vecs[i].s, vecs[i].cout, vecs[i].cmsb, vecs[i].ovf, vecs[i].zero});
            chk($sformatf("busy_at_done w%0d v%0d", w, i), {31'h0, busy_of(w)}, 32'h0);
            @(posedge clk); #1;
            chk($sformatf("done_pulse_width w%0d v%0d", w, i), {31'h0, done_of(w)}, 32'h0);
         end
      end

      // Randomized against the reference model
      for (int i = 0; i < 40; i++) begin
         int w;
         w  = i % 2;
         ra = 16'($urandom); rb = 16'($urandom);
         rs = 1'($urandom); rc = 1'($urandom);
         if (i % 10 == 3) rb = ra;
         issue(w, ra, rb, rs, rc);
         wait_done(w, 10, cyc);
         exp = model(ra, rb, rs, rc);
         chk($sformatf("rand_latency %0d", i), cyc, (w == 0) ? 4 : 1);
         chk($sformatf("rand_result %0d a=%h b=%h sub=%0d cin=%0d", i, ra, rb, rs, rc),
             {12'h0, res_of(w)}, {12'h0, exp});
      end

      // start pulses during busy cycles 2-3 are ignored
      issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk); #1;
      a_i = 16'hAAAA; b_i = 16'h5555; sub_i = 1'b1; start4 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      chk("ignored_start_done", {31'h0, done4}, 32'h1);
      chk("ignored_start_result", {12'h0, res_of(0)},
          {12'h0, model(16'h1111, 16'h2222, 1'b0, 1'b0)});
      @(posedge clk); #1;
      chk("ignored_start_idle", {30'h0, busy4, done4}, 32'h0);

      // Back-to-back: start held in the done cycle
      issue(0, 16'h4321, 16'h1234, 1'b0, 1'b1);
      wait_done(0, 10, cyc);
      chk("b2b_first_latency", cyc, 4);
      chk("b2b_first_result", {12'h0, res_of(0)},
          {12'h0, model(16'h4321, 16'h1234, 1'b0, 1'b1)});
      a_i = 16'h0010; b_i = 16'h0020; sub_i = 1'b1; cin_i = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      chk("b2b_accepted", {30'h0, busy4, done4}, 32'h2);
      wait_done(0, 10, cyc);
      chk("b2b_second_latency", cyc, 4);
      chk("b2b_second_result", {12'h0, res_of(0)},
          {12'h0, model(16'h0010, 16'h0020, 1'b1, 1'b0)});

      // Reset in the 2nd CALC cycle aborts the operation
      issue(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_outputs", {11'h0, busy4, done4, res_of(0)}, 32'h0);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (done4 || busy4) pulses++;
      end
      chk("abort_no_done", pulses, 0);
      issue(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      wait_done(0, 10, cyc);
      chk("after_abort_latency", cyc, 4);
      chk("after_abort_result", {12'h0, res_of(0)},
          {12'h0, model(16'h0F0F, 16'h00F1, 1'b0, 1'b0)});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
